// File: rtl/multi_car_racer.sv
// Multi-car racing game: paddle-steered player, bouncing enemy cars,
// scrolling track, distance score and a PLAY/CRASH/OVER game FSM.
module multi_car_racer #(
  parameter int NUM_ENEMIES  = 2,
  parameter int CRASH_FRAMES = 60,
  parameter int START_LIVES  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  hpos,
  input  logic [8:0]  vpos,
  input  logic        display_on,
  input  logic        line_tick,
  input  logic        frame_tick,
  input  logic        hpaddle,
  input  logic        vpaddle,
  output logic [2:0]  rgb,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic        game_over
);

  typedef enum logic [1:0] {
    PLAY,
    CRASH,
    OVER
  } state_t;

  localparam logic [7:0] LAST_CRASH = 8'(CRASH_FRAMES - 1);
  localparam logic [7:0] PLAYER_Y   = 8'd180;

  state_t      state;
  logic [7:0]  paddle_x;
  logic [7:0]  paddle_y;
  logic [7:0]  player_x;
  logic [7:0]  speed;
  logic [7:0]  crash_cnt;
  logic [15:0] track_pos;
  logic        collide;

  logic [7:0]  ex [NUM_ENEMIES];
  logic [7:0]  ey [NUM_ENEMIES];
  logic [NUM_ENEMIES-1:0] ed;

  logic [3:0]  step;
  logic [16:0] score_sum;
  logic [7:0]  target;
  logic [7:0]  px_clamp;

  logic enemy_pix;
  logic player_pix;
  logic offside;
  logic track_pix;
  logic shoulder;
  logic hit;
  logic r, g, b;

  // 9-bit compares so a car near the bottom extends past line 255
  function automatic logic car_pix(
    input logic [8:0] h,
    input logic [8:0] v,
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [8:0] dx;
    logic [8:0] dy;
    dx = h - {1'b0, x};
    dy = v - {1'b0, y};
    return !h[8] && (h >= {1'b0, x}) && (dx <= 9'd7)
        && (v >= {1'b0, y}) && (dy <= 9'd15);
  endfunction

  assign step      = speed[7:4];
  assign score_sum = {1'b0, score} + 17'(step);
  assign target    = ~paddle_y;

  always_comb begin
    px_clamp = paddle_x;
    if (paddle_x < 8'd64) begin
      px_clamp = 8'd64;
    end else if (paddle_x > 8'd184) begin
      px_clamp = 8'd184;
    end
  end

  always_comb begin
    enemy_pix = 1'b0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      enemy_pix = enemy_pix | car_pix(hpos, vpos, ex[i], ey[i]);
    end
  end

  assign player_pix = car_pix(hpos, vpos, player_x, PLAYER_Y)
                   && !(state == CRASH && crash_cnt[2]);
  assign offside    = (hpos[7:5] == 3'd0) || (hpos[7:5] == 3'd7);
  assign track_pix  = !hpos[8] && offside
                   && (vpos[5:1] != track_pos[5:1]);
  assign shoulder   = !hpos[8]
                   && (hpos[7:3] == 5'd3 || hpos[7:3] == 5'd28);
  assign hit        = display_on && player_pix
                   && (enemy_pix || track_pix) && (state == PLAY);

  assign r = player_pix | enemy_pix | shoulder;
  assign g = player_pix | track_pix;
  assign b = enemy_pix | shoulder;

  always_ff @(posedge clk) begin
    if (reset) begin
      paddle_x <= 8'd128;
      paddle_y <= 8'd128;
      collide  <= 1'b0;
      rgb      <= 3'd0;
    end else begin
      if (line_tick) begin
        if (!hpaddle) paddle_x <= vpos[7:0];
        if (!vpaddle) paddle_y <= vpos[7:0];
      end
      // a hit landing on the frame edge belongs to the next frame
      collide <= frame_tick ? hit : (collide | hit);
      rgb     <= {b, g, r} & {3{display_on}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PLAY;
      lives     <= 2'(START_LIVES);
      score     <= 16'd0;
      track_pos <= 16'd0;
      speed     <= 8'd31;
      crash_cnt <= 8'd0;
      player_x  <= 8'd128;
      game_over <= 1'b0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        ex[i] <= 8'(64 + 32 * i);
        ey[i] <= 8'(64 * i);
        ed[i] <= (i % 2) == 1;
      end
    end else if (frame_tick) begin
      unique case (state)
        PLAY: begin
          player_x  <= px_clamp;
          track_pos <= track_pos + 16'(step);
          score     <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
          for (int i = 0; i < NUM_ENEMIES; i++) begin
            ey[i] <= ey[i] + 8'(step);
            if (ex[i] == 8'd64 || ex[i] == 8'd192) begin
              ed[i] <= !ed[i];
              ex[i] <= ed[i] ? ex[i] - 8'd1 : ex[i] + 8'd1;
            end else begin
              ex[i] <= ed[i] ? ex[i] + 8'd1 : ex[i] - 8'd1;
            end
          end
          if (collide) begin
            speed     <= 8'd16;
            lives     <= lives - 2'd1;
            crash_cnt <= 8'd0;
            state     <= CRASH;
          end else if (speed < target) begin
            speed <= speed + 8'd1;
          end else if (speed > target) begin
            speed <= speed - 8'd1;
          end
        end
        CRASH: begin
          crash_cnt <= crash_cnt + 8'd1;
          if (crash_cnt == LAST_CRASH) begin
            if (lives != 2'd0) begin
              state <= PLAY;
            end else begin
              state     <= OVER;
              game_over <= 1'b1;
            end
          end
        end
        OVER: begin
          game_over <= 1'b1;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

endmodule
